// File: rtl/movegen_pkg.sv
// Shared constants for the systolic move generator: piece types, ray direction
// indices, pawn/castle bit positions and the emission sequencer state type.
package movegen_pkg;

    localparam int TYPE_W     = 3;
    localparam int COLOUR_BIT = 3;  // MSB of the default 4-bit piece code, 1 = white

    localparam logic [TYPE_W-1:0] PT_EMPTY = 3'd0;
    localparam logic [TYPE_W-1:0] PT_K     = 3'd1;
    localparam logic [TYPE_W-1:0] PT_Q     = 3'd2;
    localparam logic [TYPE_W-1:0] PT_R     = 3'd3;
    localparam logic [TYPE_W-1:0] PT_B     = 3'd4;
    localparam logic [TYPE_W-1:0] PT_N     = 3'd5;
    localparam logic [TYPE_W-1:0] PT_P     = 3'd6;

    localparam int DIR_N  = 0;
    localparam int DIR_NE = 1;
    localparam int DIR_E  = 2;
    localparam int DIR_SE = 3;
    localparam int DIR_S  = 4;
    localparam int DIR_SW = 5;
    localparam int DIR_W  = 6;
    localparam int DIR_NW = 7;

    localparam int KN_NNE = 0;
    localparam int KN_NEE = 1;
    localparam int KN_SEE = 2;
    localparam int KN_SSE = 3;
    localparam int KN_SSW = 4;
    localparam int KN_SWW = 5;
    localparam int KN_NWW = 6;
    localparam int KN_NNW = 7;

    localparam logic [7:0] HV_MASK   = 8'h55;
    localparam logic [7:0] DIAG_MASK = 8'hAA;

    localparam int PAWN_PUSH_N = 0;
    localparam int PAWN_PUSH_S = 1;
    localparam int PAWN_CAP_W  = 2;
    localparam int PAWN_CAP_B  = 3;

    localparam int CR_WK = 0;
    localparam int CR_WQ = 1;
    localparam int CR_BK = 2;
    localparam int CR_BQ = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_t;

    // Input index d carries the ray arriving from direction d, which travels toward d+4.
    function automatic logic [7:0] opp_dirs(input logic [7:0] v);
        return {v[3:0], v[7:4]};
    endfunction

endpackage

// File: rtl/movegen_emit_seq.sv
// Emission sequencer: holds a square's emission for SETTLE cycles so ray ripple
// through the board can settle, then pulses emit_done on the last held cycle.
module movegen_emit_seq
    import movegen_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        emit_req,
    output emit_state_t state,
    output logic        emit_start,
    output logic        emit_busy,
    output logic        emit_done
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    emit_state_t state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        emit_start = 1'b0;
        emit_busy  = 1'b0;
        emit_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (emit_req) begin
                    state_next = ST_EMIT;
                    cnt_next   = CNT_INIT;
                    emit_start = 1'b1;
                end
            end
            ST_EMIT: begin
                emit_busy = 1'b1;
                if (cnt == 4'd0) begin
                    emit_done  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/movegen_cell.sv
// Per-square cell of the systolic move generator: piece shift chain, ray emission,
// target/attack flags and a registered readout chain. Option: MOVEGEN_EP_EN (en passant).
module movegen_cell
    import movegen_pkg::*;
#(
    parameter int RANK    = 1,
    parameter int FILE    = 1,
    parameter int NRANKS  = 8,
    parameter int NFILES  = 8,
    parameter int PIECE_W = 4,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_pos_valid,
    input  logic [PIECE_W-1:0] in_pos_data,
    output logic [PIECE_W-1:0] out_pos_data,
    input  logic               wtp,
    input  logic [3:0]         i_castle_rights,
    input  logic               emit_req,
    output logic               emit_busy,
    output logic               emit_done,
    input  logic               sample,
    input  logic               attack_mode,
    input  logic               clr_attack,
    output logic [7:0]         o_king,
    input  logic [7:0]         i_king,
    output logic [7:0]         o_knight,
    input  logic [7:0]         i_knight,
    output logic [7:0]         o_slide,
    input  logic [7:0]         i_slide,
    output logic [3:0]         o_pawn,
    input  logic [3:0]         i_pawn,
    output logic               o_castle_e,
    output logic               o_castle_w,
    input  logic               i_castle_e,
    input  logic               i_castle_w,
    input  logic               ep_valid,
    input  logic [3:0]         ep_file,
    input  logic [1:0]         i_rd_chain,
    input  logic               rd_shift,
    output logic [1:0]         o_rd_chain
);

    localparam int CB      = PIECE_W - 1;
    localparam bit HOME_W  = (RANK == 1);
    localparam bit HOME_B  = (RANK == NRANKS);
    localparam bit HOME    = HOME_W || HOME_B;
    localparam bit KING_SQ = HOME && (FILE == 5);
    localparam bit CT_WEST = HOME && (FILE == 2);
    localparam bit CT_EAST = HOME && (FILE == NFILES - 1);

    logic [PIECE_W-1:0] pos;
    logic [PIECE_W-1:0] pos_e;
    logic               target_q;
    logic               attacked_q;
    emit_state_t        seq_state;
    logic               emit_start;
    logic               emitting;

    movegen_emit_seq #(.SETTLE(SETTLE)) u_seq (
        .clk        (clk),
        .rst        (rst),
        .emit_req   (emit_req),
        .state      (seq_state),
        .emit_start (emit_start),
        .emit_busy  (emit_busy),
        .emit_done  (emit_done)
    );

    assign emitting = (seq_state == ST_EMIT);

    // pos_e freezes the piece for the whole emission so chain shifting cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos   <= '0;
            pos_e <= '0;
        end else begin
            if (in_pos_valid) pos <= in_pos_data;
            if (emit_start)   pos_e <= pos;
        end
    end

    assign out_pos_data = pos;

    logic              empty;
    logic              opponent;
    logic [TYPE_W-1:0] e_type;
    logic              e_white;

    assign empty    = (pos[TYPE_W-1:0] == PT_EMPTY);
    assign opponent = !empty && (pos[CB] != wtp);
    assign e_type   = pos_e[TYPE_W-1:0];
    assign e_white  = pos_e[CB];

    always_comb begin
        o_king     = '0;
        o_knight   = '0;
        o_slide    = opp_dirs(i_slide) & {8{empty}};
        o_pawn     = '0;
        o_castle_e = 1'b0;
        o_castle_w = 1'b0;
        if (RANK == 3 && empty)          o_pawn[PAWN_PUSH_N] = i_pawn[PAWN_PUSH_N];
        if (RANK == NRANKS - 2 && empty) o_pawn[PAWN_PUSH_S] = i_pawn[PAWN_PUSH_S];
        if (HOME && !KING_SQ && empty) begin
            o_castle_e = i_castle_w;
            o_castle_w = i_castle_e;
        end
        if (emitting) begin
            case (e_type)
                PT_K: begin
                    o_king = '1;
                    if (KING_SQ && (e_white == HOME_W)) begin
                        o_castle_e = HOME_W ? i_castle_rights[CR_WK] : i_castle_rights[CR_BK];
                        o_castle_w = HOME_W ? i_castle_rights[CR_WQ] : i_castle_rights[CR_BQ];
                    end
                end
                PT_Q: o_slide = '1;
                PT_R: o_slide = o_slide | HV_MASK;
                PT_B: o_slide = o_slide | DIAG_MASK;
                PT_N: o_knight = '1;
                PT_P: begin
                    if (e_white) begin
                        o_pawn[PAWN_PUSH_N] = 1'b1;
                        o_pawn[PAWN_CAP_W]  = 1'b1;
                    end else begin
                        o_pawn[PAWN_PUSH_S] = 1'b1;
                        o_pawn[PAWN_CAP_B]  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic push_in;
    logic cap_in;
    logic castle_tgt;
    logic ep_hit;
    logic target_comb;
    logic attack_in;

    assign push_in    = wtp ? i_pawn[PAWN_PUSH_N] : i_pawn[PAWN_PUSH_S];
    assign cap_in     = wtp ? i_pawn[PAWN_CAP_W] : i_pawn[PAWN_CAP_B];
    assign castle_tgt = (CT_WEST && i_castle_e) || (CT_EAST && i_castle_w);

`ifdef MOVEGEN_EP_EN
    assign ep_hit = ep_valid && empty && (ep_file == 4'(FILE)) &&
                    ((RANK == 6 && wtp && i_pawn[PAWN_CAP_W]) ||
                     (RANK == 3 && !wtp && i_pawn[PAWN_CAP_B]));
`else
    logic ep_unused;
    assign ep_unused = ep_valid ^ (|ep_file);
    assign ep_hit    = 1'b0;
`endif

    assign target_comb = (push_in && empty) || (cap_in && opponent) || ep_hit ||
                         (((|i_king) || (|i_knight) || (|i_slide) || castle_tgt) &&
                          (empty || opponent));
    assign attack_in   = (|i_king) || (|i_knight) || (|i_slide) ||
                         i_pawn[PAWN_CAP_W] || i_pawn[PAWN_CAP_B];

    // A sample overrides the shift only for the flag it writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= 1'b0;
            attacked_q <= 1'b0;
        end else begin
            if (sample && !attack_mode) target_q <= target_comb;
            else if (rd_shift)          target_q <= i_rd_chain[0];

            if (clr_attack)                attacked_q <= 1'b0;
            else if (sample && attack_mode) attacked_q <= attacked_q || attack_in;
            else if (rd_shift)             attacked_q <= i_rd_chain[1];
        end
    end

    assign o_rd_chain = {attacked_q, target_q};

endmodule

// File: tb/tb_movegen_cell.sv
// Directed bench for movegen_cell: vector table for rays/targets, plus sequences for
// emission timing, attack accumulation, readout chain, reset abort and en passant.
module tb_movegen_cell;

    logic       clk = 1'b0;
    logic       rst;
    logic       pos_valid;
    logic [3:0] pos_data;
    logic       wtp;
    logic [3:0] rights;
    logic       emit_req;
    logic       sample;
    logic       attack_mode;
    logic       clr_attack;
    logic       rd_shift;
    logic       ep_valid;
    logic [3:0] ep_file;
    logic [7:0] i_king;
    logic [7:0] i_knight;
    logic [7:0] i_slide;
    logic [3:0] i_pawn;
    logic       i_castle_e;
    logic       i_castle_w;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Main cell (d4, SETTLE = 2)
    logic [3:0] m_pos_out;
    logic       m_busy, m_done, m_ce, m_cw;
    logic [7:0] m_king, m_knight, m_slide;
    logic [3:0] m_pawn;
    logic [1:0] m_rd;

    movegen_cell #(.RANK(4), .FILE(4), .SETTLE(2)) u_main (
        .clk(clk), .rst(rst), .in_pos_valid(pos_valid), .in_pos_data(pos_data),
        .out_pos_data(m_pos_out), .wtp(wtp), .i_castle_rights(rights),
        .emit_req(emit_req), .emit_busy(m_busy), .emit_done(m_done),
        .sample(sample), .attack_mode(attack_mode), .clr_attack(clr_attack),
        .o_king(m_king), .i_king(i_king), .o_knight(m_knight), .i_knight(i_knight),
        .o_slide(m_slide), .i_slide(i_slide), .o_pawn(m_pawn), .i_pawn(i_pawn),
        .o_castle_e(m_ce), .o_castle_w(m_cw), .i_castle_e(i_castle_e), .i_castle_w(i_castle_w),
        .ep_valid(ep_valid), .ep_file(ep_file), .i_rd_chain(2'b00), .rd_shift(rd_shift),
        .o_rd_chain(m_rd)
    );

    // En-passant candidate cell (rank 6, file 4), always empty
    logic [3:0] e_pos_out;
    logic       e_busy, e_done, e_ce, e_cw;
    logic [7:0] e_king, e_knight, e_slide;
    logic [3:0] e_pawn;
    logic [1:0] e_rd;

    movegen_cell #(.RANK(6), .FILE(4)) u_ep (
        .clk(clk), .rst(rst), .in_pos_valid(1'b0), .in_pos_data(4'h0),
        .out_pos_data(e_pos_out), .wtp(wtp), .i_castle_rights(rights),
        .emit_req(1'b0), .emit_busy(e_busy), .emit_done(e_done),
        .sample(sample), .attack_mode(attack_mode), .clr_attack(clr_attack),
        .o_king(e_king), .i_king(i_king), .o_knight(e_knight), .i_knight(i_knight),
        .o_slide(e_slide), .i_slide(i_slide), .o_pawn(e_pawn), .i_pawn(i_pawn),
        .o_castle_e(e_ce), .o_castle_w(e_cw), .i_castle_e(i_castle_e), .i_castle_w(i_castle_w),
        .ep_valid(ep_valid), .ep_file(ep_file), .i_rd_chain(2'b00), .rd_shift(rd_shift),
        .o_rd_chain(e_rd)
    );

    // Four-cell readout chain, empty cells driven by per-cell king rays
    logic [7:0] c_king_in [4];
    logic [1:0] rd_link   [5];
    logic [3:0] c_pos_out [4];
    logic       c_busy [4], c_done [4], c_ce [4], c_cw [4];
    logic [7:0] c_king [4], c_knight [4], c_slide [4];
    logic [3:0] c_pawn [4];

    assign rd_link[0] = 2'b00;

    for (genvar g = 0; g < 4; g++) begin : g_chain
        movegen_cell #(.RANK(4), .FILE(g + 1)) u_c (
            .clk(clk), .rst(rst), .in_pos_valid(1'b0), .in_pos_data(4'h0),
            .out_pos_data(c_pos_out[g]), .wtp(wtp), .i_castle_rights(rights),
            .emit_req(1'b0), .emit_busy(c_busy[g]), .emit_done(c_done[g]),
            .sample(sample), .attack_mode(attack_mode), .clr_attack(clr_attack),
            .o_king(c_king[g]), .i_king(c_king_in[g]), .o_knight(c_knight[g]), .i_knight(8'h00),
            .o_slide(c_slide[g]), .i_slide(8'h00), .o_pawn(c_pawn[g]), .i_pawn(4'h0),
            .o_castle_e(c_ce[g]), .o_castle_w(c_cw[g]), .i_castle_e(1'b0), .i_castle_w(1'b0),
            .ep_valid(1'b0), .ep_file(4'h0), .i_rd_chain(rd_link[g]), .rd_shift(rd_shift),
            .o_rd_chain(rd_link[g + 1])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_piece(input logic [3:0] p);
        pos_data  = p;
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic do_sample(input logic mode);
        attack_mode = mode;
        sample      = 1'b1;
        tick();
        sample      = 1'b0;
        attack_mode = 1'b0;
    endtask

    task automatic clear_rays();
        i_king   = '0;
        i_knight = '0;
        i_slide  = '0;
        i_pawn   = '0;
    endtask

    typedef struct {
        logic [3:0] pos;
        logic       wtp;
        logic [7:0] king;
        logic [7:0] knight;
        logic [7:0] slide;
        logic [3:0] pawn;
        logic [7:0] exp_slide;
        logic       exp_tgt;
    } vec_t;

    vec_t vecs [14];
    logic ser_exp [4];
    logic ep_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          pos    wtp   king   knight slide  pawn   exp_sl tgt
        vecs[0]  = '{4'h0, 1'b1, 8'h00, 8'h00, 8'h10, 4'h0, 8'h01, 1'b1};
        vecs[1]  = '{4'hB, 1'b1, 8'h00, 8'h00, 8'h10, 4'h0, 8'h00, 1'b0};
        vecs[2]  = '{4'h3, 1'b1, 8'h00, 8'h00, 8'h10, 4'h0, 8'h00, 1'b1};
        vecs[3]  = '{4'h6, 1'b1, 8'h00, 8'h00, 8'h00, 4'h4, 8'h00, 1'b1};
        vecs[4]  = '{4'hE, 1'b1, 8'h00, 8'h00, 8'h00, 4'h4, 8'h00, 1'b0};
        vecs[5]  = '{4'h0, 1'b1, 8'h00, 8'h00, 8'h00, 4'h1, 8'h00, 1'b1};
        vecs[6]  = '{4'h3, 1'b1, 8'h00, 8'h00, 8'h00, 4'h1, 8'h00, 1'b0};
        vecs[7]  = '{4'h0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h4, 8'h00, 1'b0};
        vecs[8]  = '{4'h0, 1'b0, 8'h00, 8'h80, 8'h00, 4'h0, 8'h00, 1'b1};
        vecs[9]  = '{4'h1, 1'b0, 8'h01, 8'h00, 8'h00, 4'h0, 8'h00, 1'b0};
        vecs[10] = '{4'h0, 1'b1, 8'h00, 8'h00, 8'h22, 4'h0, 8'h22, 1'b1};
        vecs[11] = '{4'h0, 1'b1, 8'h00, 8'h00, 8'h0C, 4'h0, 8'hC0, 1'b1};
        vecs[12] = '{4'h5, 1'b0, 8'h00, 8'h00, 8'h00, 4'h8, 8'h00, 1'b0};
        vecs[13] = '{4'hD, 1'b0, 8'h00, 8'h00, 8'h00, 4'h8, 8'h00, 1'b1};
        ser_exp  = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef MOVEGEN_EP_EN
        ep_exp = 1'b1;
`else
        ep_exp = 1'b0;
`endif

        rst = 1'b1; pos_valid = 1'b0; pos_data = '0; wtp = 1'b1; rights = 4'hF;
        emit_req = 1'b0; sample = 1'b0; attack_mode = 1'b0; clr_attack = 1'b0;
        rd_shift = 1'b0; ep_valid = 1'b0; ep_file = '0; i_castle_e = 1'b0; i_castle_w = 1'b0;
        clear_rays();
        for (int i = 0; i < 4; i++) c_king_in[i] = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", 32'(m_busy), 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_rd", 32'(m_rd), 0);
        check("rst_pos", 32'(m_pos_out), 0);
        check("rst_slide", 32'(m_slide), 0);

        for (int i = 0; i < 14; i++) begin
            load_piece(vecs[i].pos);
            wtp      = vecs[i].wtp;
            i_king   = vecs[i].king;
            i_knight = vecs[i].knight;
            i_slide  = vecs[i].slide;
            i_pawn   = vecs[i].pawn;
            #1;
            check($sformatf("vec%0d_slide", i), 32'(m_slide), 32'(vecs[i].exp_slide));
            do_sample(1'b0);
            check($sformatf("vec%0d_target", i), 32'(m_rd[0]), 32'(vecs[i].exp_tgt));
            clear_rays();
        end

        // Sticky attack accumulation and clear priority
        check("atk_initial", 32'(m_rd[1]), 0);
        do_sample(1'b1);
        check("atk_s1", 32'(m_rd[1]), 0);
        i_knight = 8'h01;
        do_sample(1'b1);
        i_knight = 8'h00;
        check("atk_s2", 32'(m_rd[1]), 1);
        do_sample(1'b1);
        check("atk_s3_sticky", 32'(m_rd[1]), 1);
        i_knight   = 8'h01;
        clr_attack = 1'b1;
        do_sample(1'b1);
        clr_attack = 1'b0;
        i_knight   = 8'h00;
        check("atk_clr_prio", 32'(m_rd[1]), 0);

        // Rook emission over SETTLE = 2, with a piece shift mid-emission
        load_piece(4'hB);
        emit_req = 1'b1;
        tick();
        emit_req = 1'b0;
        check("emit1_busy", 32'(m_busy), 1);
        check("emit1_slide", 32'(m_slide), 32'h55);
        check("emit1_done", 32'(m_done), 0);
        check("emit1_king", 32'(m_king), 0);
        load_piece(4'hC);
        check("emit2_busy", 32'(m_busy), 1);
        check("emit2_slide_snap", 32'(m_slide), 32'h55);
        check("emit2_done", 32'(m_done), 1);
        tick();
        check("emit3_busy", 32'(m_busy), 0);
        check("emit3_done", 32'(m_done), 0);
        check("emit3_slide", 32'(m_slide), 0);
        emit_req = 1'b1;
        tick();
        emit_req = 1'b0;
        check("bishop_slide", 32'(m_slide), 32'hAA);
        tick();
        check("bishop_done", 32'(m_done), 1);
        tick();

        // Reset in the middle of an emission
        emit_req = 1'b1;
        tick();
        emit_req = 1'b0;
        check("abort_busy_pre", 32'(m_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(m_busy), 0);
        check("abort_done", 32'(m_done), 0);
        check("abort_slide", 32'(m_slide), 0);
        check("abort_pos", 32'(m_pos_out), 0);
        tick();
        check("abort_done_late", 32'(m_done), 0);

        // Readout chain: targets 1,0,1,1 shift out of the last cell as 1,1,0,1
        c_king_in[0] = 8'h01; c_king_in[1] = 8'h00; c_king_in[2] = 8'h01; c_king_in[3] = 8'h01;
        do_sample(1'b0);
        for (int i = 0; i < 4; i++) c_king_in[i] = '0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("chain_bit%0d", k), 32'(rd_link[4][0]), 32'(ser_exp[k]));
            rd_shift = 1'b1;
            tick();
            rd_shift = 1'b0;
        end

        // Sample and shift together: sampled bit wins, the other bit shifts
        c_king_in[0] = 8'h01;
        do_sample(1'b0);
        attack_mode = 1'b1;
        sample      = 1'b1;
        rd_shift    = 1'b1;
        tick();
        sample = 1'b0; rd_shift = 1'b0; attack_mode = 1'b0;
        c_king_in[0] = 8'h00;
        check("coinc_cell0", 32'(rd_link[1]), 32'h2);
        check("coinc_cell1", 32'(rd_link[2]), 32'h1);

        // En passant on an empty rank-6 cell
        wtp = 1'b1; ep_valid = 1'b1; ep_file = 4'd4; i_pawn = 4'h4;
        do_sample(1'b0);
        check("ep_match", 32'(e_rd[0]), 32'(ep_exp));
        ep_file = 4'd3;
        do_sample(1'b0);
        check("ep_wrong_file", 32'(e_rd[0]), 0);
        ep_valid = 1'b0;
        clear_rays();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
